// File: rtl/scpad_frontend_arb_if.sv
// Requester and SRAM command signals for the scratchpad front-end arbiter.
// master = arbiter view; slave = requesters plus the SRAM controller.
interface scpad_frontend_arb_if #(
    parameter int NUM_REQ       = 3,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int NUM_COLS      = 32,
    parameter int LEN_WIDTH     = 5
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_ready;
    logic [NUM_REQ-1:0]                    req_write;
    logic [NUM_REQ-1:0][ROW_IDX_WIDTH-1:0] req_row_base;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]     req_len;
    logic [NUM_REQ-1:0][NUM_COLS-1:0]      req_mask;
    logic [NUM_REQ-1:0]                    req_done;

    logic                     sram_valid;
    logic                     sram_ready;
    logic                     sram_write;
    logic [ROW_IDX_WIDTH-1:0] sram_row;
    logic [NUM_COLS-1:0]      sram_mask;
    logic [SRC_W-1:0]         sram_src_id;
    logic                     sram_last;
    logic                     busy;

    modport master (
        input  req_valid, req_write, req_row_base, req_len, req_mask, sram_ready,
        output req_ready, req_done, sram_valid, sram_write, sram_row, sram_mask,
               sram_src_id, sram_last, busy
    );

    modport slave (
        output req_valid, req_write, req_row_base, req_len, req_mask, sram_ready,
        input  req_ready, req_done, sram_valid, sram_write, sram_row, sram_mask,
               sram_src_id, sram_last, busy
    );
endinterface

// File: rtl/scpad_frontend_arb.sv
// Round-robin arbiter that locks one tile-row burst descriptor and issues it
// to the scratchpad SRAM controller as one row command per accepted beat.
module scpad_frontend_arb #(
    parameter int NUM_REQ       = 3,
    parameter int ROW_IDX_WIDTH = 14,
    parameter int NUM_COLS      = 32,
    parameter int LEN_WIDTH     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    scpad_frontend_arb_if.master bus
);
    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                   state_q, state_d;
    logic [SRC_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]         gnt_q;
    logic [LEN_WIDTH-1:0]     beat_cnt_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [ROW_IDX_WIDTH-1:0] row_q;
    logic [NUM_COLS-1:0]      mask_q;
    logic                     write_q;
    logic                     last_q;
    logic [NUM_REQ-1:0]       done_q;

    logic                     win_found;
    logic [SRC_W-1:0]         win_idx;
    logic [NUM_REQ-1:0]       ready_onehot;
    logic                     accept;
    logic                     beat_hs;
    logic                     burst_end;

    // Walk downward so the requester closest to rr_ptr is the last one kept.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_onehot[gi] = !rst && (state_q == S_IDLE) && win_found
                                      && (win_idx == SRC_W'(gi));
        end
    endgenerate

    assign accept    = !rst && (state_q == S_IDLE) && win_found;
    assign beat_hs   = (state_q == S_BURST) && bus.sram_ready;
    assign burst_end = beat_hs && last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_BURST;
            end
            S_BURST: begin
                if (burst_end) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (gnt_q == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_q + SRC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // row_q tracks base + beat_cnt directly so the row output stays a plain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            row_q      <= '0;
            mask_q     <= '0;
            write_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            done_q <= '0;
            if (accept) begin
                gnt_q      <= win_idx;
                beat_cnt_q <= '0;
                len_q      <= bus.req_len[win_idx];
                row_q      <= bus.req_row_base[win_idx];
                mask_q     <= bus.req_mask[win_idx];
                write_q    <= bus.req_write[win_idx];
                last_q     <= (bus.req_len[win_idx] == '0);
            end else if (beat_hs) begin
                if (last_q) begin
                    done_q <= NUM_REQ'(1) << gnt_q;
                end else begin
                    beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
                    row_q      <= row_q + ROW_IDX_WIDTH'(1);
                    last_q     <= ((beat_cnt_q + LEN_WIDTH'(1)) == len_q);
                end
            end
        end
    end

    always_comb begin
        bus.req_ready   = ready_onehot;
        bus.req_done    = done_q;
        bus.sram_valid  = (state_q == S_BURST);
        bus.busy        = (state_q == S_BURST);
        bus.sram_write  = write_q;
        bus.sram_row    = row_q;
        bus.sram_mask   = mask_q;
        bus.sram_src_id = gnt_q;
        bus.sram_last   = last_q;
    end
endmodule

// File: doc/scpad_frontend_arb.md
Name: scpad_frontend_arb

Overview:
- Arbitrates one scratchpad SRAM controller command port among NUM_REQ requesters: 0 = backend prefetcher, 1 = systolic-array frontend, 2 = vector-core frontend.
- Each requester submits a tile-row burst descriptor: base row, row count, write flag, valid mask. The winner is granted round-robin.
- The winner's descriptor is locked and issued as one row command per accepted beat to the SRAM controller. The requester receives a done pulse when its burst completes.

Parameters:
- NUM_REQ, 3, number of requesters (2..4)
- ROW_IDX_WIDTH, 14, SRAM row index width (16384 rows of 64 B)
- NUM_COLS, 32, elements per row; width of the valid mask
- LEN_WIDTH, 5, burst length field, encoded as rows-1 (1..32 rows)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  descriptor valid, per requester
- req_ready  out  NUM_REQ  descriptor accepted, per requester
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst
- req_row_base  in  NUM_REQ x ROW_IDX_WIDTH  first row
- req_len  in  NUM_REQ x LEN_WIDTH  rows-1
- req_mask  in  NUM_REQ x NUM_COLS  column valid mask, applied to every beat
- req_done  out  NUM_REQ  one-cycle burst-complete pulse
- sram_valid  out  1  row command valid
- sram_ready  in  1  SRAM controller accepts command
- sram_write  out  1  command direction
- sram_row  out  ROW_IDX_WIDTH  row index
- sram_mask  out  NUM_COLS  column mask
- sram_src_id  out  $clog2(NUM_REQ)  owning requester, used for crossbar steering
- sram_last  out  1  final beat of burst
- busy  out  1  burst in progress

Behaviour:
- Clocking and reset: single clock domain, clk; reset rst is synchronous, active-high.
- Reset values:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0.
  - All outputs 0: req_ready, req_done, sram_valid, sram_write, sram_row, sram_mask, sram_src_id, sram_last, busy.
- FSM states: IDLE, BURST.
- IDLE:
  - Winner g = first index with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g] = 1 combinationally in the same cycle; all other req_ready = 0.
  - On that cycle, capture g, base, len, write, mask into registers and clear beat_cnt. Next state = BURST.
  - No req_valid set: stay IDLE, all req_ready = 0.
- BURST:
  - All req_ready = 0; busy = 1; sram_valid = 1.
  - sram_row = (base + beat_cnt) mod 2^ROW_IDX_WIDTH, i.e. natural wrap from the last row to row 0.
  - sram_write, sram_mask, sram_src_id come from the captured registers.
  - sram_last = (beat_cnt == len).
- Beat handshake:
  - Occurs when sram_valid && sram_ready. beat_cnt increments by 1.
  - If sram_last: next state = IDLE, rr_ptr = (g+1) mod NUM_REQ, and req_done[g] pulses for exactly the next cycle.
- Stall: while sram_valid && !sram_ready, all sram_* outputs hold stable.
- Latency:
  - Descriptor accept to first sram_valid: 1 cycle.
  - Burst of L rows with sram_ready held high: L cycles in BURST.
  - One mandatory IDLE bubble between consecutive bursts.
- Outputs: sram_*, busy and req_done are driven from registers. req_ready is the only combinational output.
- Back-to-back: in the IDLE cycle where req_done pulses, a new descriptor (including from the same requester) may be accepted.
- Fairness: rr_ptr advances only on burst completion. A requester that keeps req_valid asserted waits at most NUM_REQ-1 bursts.
- Requester descriptor fields are sampled only in the accept cycle. Later changes to the inputs do not affect the burst in flight.
- req_valid deasserted by the winner in the accept cycle: no accept occurs, since ready and valid are evaluated together in the same cycle.
- Reset mid-burst: the burst is abandoned with no req_done. Reset values apply on the next edge.
- len = 31 produces exactly 32 beats; beat_cnt width is LEN_WIDTH and never overflows past len.

Test Plan:
- Single burst, sram_ready=1: req_valid[1], base=0x0010, len=3, mask=0xFFFF_FFFF.
  - req_ready[1] pulses once.
  - sram_row = 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles, src_id=1, sram_last only on 0x13.
  - req_done[1] pulses the cycle after.
- Contention: all three requesters valid from reset.
  - Grant order 0, 1, 2, each burst preceded by one IDLE cycle.
  - Requester 0 re-asserts after its done → it is served after 2, not before 1.
- Row wrap: base=0x3FFE, len=3 → sram_row = 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- Backpressure: len=1, sram_ready low for 3 cycles at beat 0.
  - sram_row, sram_mask and sram_last stay constant through the stall.
  - Exactly 2 handshakes total; done after the second.
- Max length: len=31, write=1, mask=0x0000_00FF → 32 beats, all with sram_write=1 and mask 0xFF, last on beat 31.
- Reset mid-burst: assert rst at beat 2 of a 5-row burst.
  - Next cycle: sram_valid=0, busy=0, no req_done.
  - Subsequent grants restart with rr_ptr=0.
